// File: rtl/memory_arbiter.sv
// memory_arbiter: per-core request FIFOs feeding a round-robin issue stage toward the
// shared memory controller, plus zero-latency response demux by core_id.
package memory_arbiter_pkg;
  localparam int CORE_ID_W = 3;

  typedef enum logic [1:0] {
    READ_REQ  = 2'd0,
    WRITE_REQ = 2'd1,
    READ_RSP  = 2'd2,
    WRITE_RSP = 2'd3
  } access_t;

  typedef struct packed {
    logic                 vld;
    logic [CORE_ID_W-1:0] core_id;
    access_t              access_type;
    logic [3:0]           access_id;
    logic [15:0]          addr;
    logic [31:0]          data;
    logic [3:0]           byte_en;
  } request_t;
endpackage

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             core_req [NUM_CORES],
  output logic [NUM_CORES-1:0] core_req_rdy,
  output request_t             core_rsp [NUM_CORES],
  output request_t             mem_req,
  input  request_t             mem_rsp,
  output logic                 rsp_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_CORES);

  request_t             r_fifoMem [NUM_CORES][FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr   [NUM_CORES];
  logic [PTR_W-1:0]     r_rdPtr   [NUM_CORES];
  logic [CNT_W-1:0]     r_count   [NUM_CORES];
  logic [IDX_W-1:0]     r_rrPtr;
  request_t             r_memReq;
  logic                 r_rspErr;

  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;
  logic [NUM_CORES-1:0] w_notEmpty;
  logic                 w_grant;
  logic [IDX_W-1:0]     w_grantIdx;
  request_t             w_head;
  logic                 w_badId;

  // Both operands are below NUM_CORES, so one conditional subtract performs the wrap.
  function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CORES) sum = sum - NUM_CORES;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_notEmpty[i]   = (r_count[i] != '0);
      core_req_rdy[i] = (r_count[i] != CNT_W'(FIFO_DEPTH));
      w_push[i]       = core_req[i].vld & core_req_rdy[i];
    end
  end

  always_comb begin
    w_grant    = 1'b0;
    w_grantIdx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!w_grant && w_notEmpty[rrIndex(r_rrPtr, k)]) begin
        w_grant    = 1'b1;
        w_grantIdx = rrIndex(r_rrPtr, k);
      end
    end
    w_pop = '0;
    if (w_grant) w_pop[w_grantIdx] = 1'b1;
    w_head = r_fifoMem[w_grantIdx][r_rdPtr[w_grantIdx]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
        if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Storage needs no reset: emptiness is tracked solely by the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_push[i]) r_fifoMem[i][r_wrPtr[i]] <= core_req[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memReq <= '0;
      r_rrPtr  <= '0;
    end else if (w_grant) begin
      r_memReq         <= w_head;
      r_memReq.vld     <= 1'b1;
      r_memReq.core_id <= CORE_ID_W'(w_grantIdx);
      r_rrPtr          <= rrIndex(w_grantIdx, 1);
    end else begin
      r_memReq.vld <= 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      core_rsp[i]     = mem_rsp;
      core_rsp[i].vld = mem_rsp.vld && (mem_rsp.core_id == CORE_ID_W'(i));
    end
  end

  assign w_badId = mem_rsp.vld && (int'(mem_rsp.core_id) >= NUM_CORES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_rspErr <= 1'b0;
    else if (w_badId) r_rspErr <= 1'b1;
  end

  assign mem_req = r_memReq;
  assign rsp_err = r_rspErr;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single memory_controller port among `NUM_CORES` requesting cores. Each core gets a small request FIFO with ready backpressure, and a round-robin arbiter issues at most one request per cycle to the memory controller. Responses come back after the controller's fixed 2-cycle latency and are demultiplexed to the issuing core by `core_id`. The block sits between the core request buses and `memory_controller.core_req`/`core_rsp`.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requester ports; must be at least 2 and at most 2^width(`request_t.core_id`).
- `FIFO_DEPTH`, 2: per-core request FIFO entries; must be a power of 2 and at least 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named `clk` and `reset` as in the rest of the codebase.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous active-low reset.
- `core_req[NUM_CORES]`, in, `request_t`: per-core request; a request is offered when `.vld` = 1.
- `core_req_rdy`, out, `NUM_CORES`: per-core accept; a request is accepted when `vld & rdy` are both 1.
- `core_rsp[NUM_CORES]`, out, `request_t`: per-core routed response.
- `mem_req`, out, `request_t`: request to memory_controller `core_req`.
- `mem_rsp`, in, `request_t`: response from memory_controller `core_rsp`.
- `rsp_err`, out, 1: sticky flag; set when a response arrives with `core_id` ≥ `NUM_CORES`.

## Operation
- **FIFO push:** port i pushes the full `request_t` into FIFO i when `core_req[i].vld & core_req_rdy[i]`.
- **Ready:** `core_req_rdy[i] = !full_i`. Ready is combinational from the FIFO count. It does not consider a same-cycle pop, so a full FIFO never accepts a push.
- **Arbitration:** combinational round-robin over non-empty FIFO heads.
  - A priority pointer `rr_ptr` resets to 0.
  - The search starts at `rr_ptr` and wraps modulo `NUM_CORES`. The first non-empty FIFO wins.
  - On a grant to index g, `rr_ptr <= (g+1) mod NUM_CORES`. With no grant, `rr_ptr` holds.
- **Issue:** the winning FIFO pops in the same cycle. `mem_req` is registered and loads the head entry with these fields:
  - `vld` = 1.
  - `core_id` is overwritten with the port index g, zero-extended.
  - All other fields (`access_type`, `access_id`, `addr`, `data`, `byte_en`) are copied unchanged.
  - With no grant, `mem_req.vld <= 0` and the other fields hold.
- **Response routing:** combinational, zero latency.
  - `core_rsp[i]` = `mem_rsp` with `.vld = mem_rsp.vld & (mem_rsp.core_id == i)`. Other fields are broadcast to every port.
  - If `mem_rsp.vld` and `core_id` ≥ `NUM_CORES`: no port sees `vld`, and `rsp_err <= 1`. `rsp_err` clears only on reset.
- **No backpressure toward memory:** the memory controller accepts every cycle and cores must accept every response, so the block keeps no outstanding-request count.
- **Ordering:** requests from one core issue in FIFO order. The controller latency is fixed, so responses return in the same order.

## Timing
- **Reset values:**
  - FIFOs empty; `core_req_rdy` = all 1s.
  - `mem_req` all fields 0; `rr_ptr` = 0; `rsp_err` = 0.
  - `core_rsp[*].vld` = 0 (follows `mem_rsp`, which the memory controller also resets).
- **Uncontended latency:**
  - Accepted at cycle t → in FIFO at t+1 → `mem_req.vld` at t+2 → `mem_rsp`/`core_rsp[i].vld` at t+4.
  - The controller latches at the end of t+2, and its 2-stage response pipe yields the response at t+4.
- **Throughput:** one `mem_req` per cycle. A single core sustains 1 request per cycle when it is the only requester, because the FIFO never exceeds 1 entry.
- **Contention:** k non-empty FIFOs are served in k consecutive cycles in round-robin order. Worst-case wait before issue is `NUM_CORES`-1 cycles after reaching the FIFO head.
- **Simultaneous push and pop on the same FIFO:** allowed when not full; count is unchanged.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.
- **Reset mid-operation:** every FIFO entry and the `mem_req` register are discarded immediately (asynchronous). In-flight controller responses are cleared by the shared reset. No stale `core_rsp` is produced after reset deasserts.

## Test plan
- **Single read, core 2:** read with `addr`=0x10, `access_id`=5 at cycle 0, memory `q`=0xA5.
  - `mem_req.vld` at cycle 2 with `core_id`=2.
  - `core_rsp[2].vld` at cycle 4 with `READ_RSP`, `data`=0xA5, `access_id`=5.
  - `core_rsp[0,1,3].vld` stay 0.
- **Four-way contention:** all 4 cores issue one write in cycle 0 with `rr_ptr`=0.
  - `mem_req.core_id` = 0,1,2,3 on cycles 2,3,4,5.
  - `WRITE_RSP` appears on ports 0..3 on cycles 4..7; `rsp.data`=0.
- **Fairness after wrap:** set `rr_ptr`=3 by granting core 2 first, then make cores 0 and 3 pending. Core 3 is granted before core 0.
- **Backpressure:** hold core 1 `vld` high for 6 cycles while cores 0, 2 and 3 also stream continuously.
  - `core_req_rdy[1]` drops once FIFO 1 holds 2 entries.
  - No request is lost or duplicated; the 6 responses return in order of `access_id`.
- **Reset mid-operation:** assert `reset` low at cycle 3 with 3 requests queued and 1 in flight.
  - All outputs reach reset values while reset is low.
  - After release, no `core_rsp` valid appears without a new request, and `rdy` = all 1s.
- **Bad `core_id`:** force `mem_rsp.vld`=1 with `core_id`=7 and `NUM_CORES`=4.
  - No `core_rsp` valid.
  - `rsp_err`=1 next cycle and stays set until reset.
